// File: rtl/eh2_lsu_ecc_corr_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : eh2_lsu_ecc_corr_wb_if
// Purpose  : Bundles the correction input, DCCM write-port request/grant and
//            status signals of the ECC correction write-back block.
//            master : correction source / write arbiter / TLU side
//            slave  : eh2_lsu_ecc_corr_wb
// Signals  : corr_valid, corr_addr, corr_data, ecc_disable, cnt_clr  (m->s)
//            wr_gnt                                                  (m->s)
//            wr_req, wr_addr, wr_data                                (s->m)
//            corr_cnt, full, drop_pulse, overflow                    (s->m)
// Revision : 1.0  initial release
// ============================================================================
interface eh2_lsu_ecc_corr_wb_if #(
    parameter int DCCM_BITS       = 16,
    parameter int DCCM_DATA_WIDTH = 32,
    parameter int DCCM_ECC_WIDTH  = 7,
    parameter int CNT_WIDTH       = 16
);
    logic                                      corr_valid;
    logic [DCCM_BITS-1:0]                      corr_addr;
    logic [DCCM_DATA_WIDTH-1:0]                corr_data;
    logic                                      ecc_disable;
    logic                                      wr_req;
    logic                                      wr_gnt;
    logic [DCCM_BITS-1:0]                      wr_addr;
    logic [DCCM_DATA_WIDTH+DCCM_ECC_WIDTH-1:0] wr_data;
    logic                                      cnt_clr;
    logic [CNT_WIDTH-1:0]                      corr_cnt;
    logic                                      full;
    logic                                      drop_pulse;
    logic                                      overflow;

    modport master (
        output corr_valid, corr_addr, corr_data, ecc_disable, wr_gnt, cnt_clr,
        input  wr_req, wr_addr, wr_data, corr_cnt, full, drop_pulse, overflow
    );

    modport slave (
        input  corr_valid, corr_addr, corr_data, ecc_disable, wr_gnt, cnt_clr,
        output wr_req, wr_addr, wr_data, corr_cnt, full, drop_pulse, overflow
    );
endinterface
`default_nettype wire

// File: rtl/eh2_lsu_ecc_corr_wb.sv
`default_nettype none
// ============================================================================
// Module   : eh2_lsu_ecc_corr_wb
// Purpose  : Write-back of single-bit-corrected DCCM words. Corrected
//            {addr, data} pairs are queued in a small circular FIFO (with
//            same-word merging), SEC-DED check bits are regenerated from the
//            head entry, and the DCCM write port is requested until granted.
//            Also keeps a saturating corrected-error count and a sticky
//            overflow flag for dropped corrections.
// Ports    : clk, rst (sync, active-high)
//            bus.corr_valid/corr_addr/corr_data/ecc_disable : correction in
//            bus.wr_req/wr_gnt/wr_addr/wr_data              : DCCM write port
//            bus.cnt_clr/corr_cnt                           : error counter
//            bus.full/drop_pulse/overflow                   : queue status
// Revision : 1.0  initial release
// ============================================================================
module eh2_lsu_ecc_corr_wb #(
    parameter int DCCM_BITS       = 16,
    parameter int DCCM_DATA_WIDTH = 32,
    parameter int DCCM_ECC_WIDTH  = 7,
    parameter int DEPTH           = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    eh2_lsu_ecc_corr_wb_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_WA_W  = DCCM_BITS - 2;
    localparam logic [c_PTR_W:0] c_DEPTH_CNT = (c_PTR_W+1)'(DEPTH);

    // Hsiao/Hamming SEC-DED generator matching rvecc_encode bit for bit.
    function automatic logic [6:0] f_ecc(input logic [31:0] d);
        logic [6:0] e;
        e[0] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[11]^d[13]^d[15]^d[17]
             ^ d[19]^d[21]^d[23]^d[25]^d[26]^d[28]^d[30];
        e[1] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[10]^d[12]^d[13]^d[16]^d[17]
             ^ d[20]^d[21]^d[24]^d[25]^d[27]^d[28]^d[31];
        e[2] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[10]^d[14]^d[15]^d[16]^d[17]
             ^ d[22]^d[23]^d[24]^d[25]^d[29]^d[30]^d[31];
        e[3] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[10]^d[18]^d[19]^d[20]^d[21]
             ^ d[22]^d[23]^d[24]^d[25];
        e[4] = d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[20]
             ^ d[21]^d[22]^d[23]^d[24]^d[25];
        e[5] = d[26]^d[27]^d[28]^d[29]^d[30]^d[31];
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    // Queue storage and pointers
    logic [c_WA_W-1:0]          r_addr [DEPTH];
    logic [DCCM_DATA_WIDTH-1:0] r_data [DEPTH];
    logic [c_PTR_W-1:0]         r_head;
    logic [c_PTR_W-1:0]         r_tail;
    logic [c_PTR_W:0]           r_count;
    logic [CNT_WIDTH-1:0]       r_cnt;
    logic                       r_drop;
    logic                       r_ovf;

    logic                       w_empty;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_accept;
    logic [DEPTH-1:0]           w_hit;
    logic                       w_merge;
    logic [c_PTR_W-1:0]         w_merge_idx;
    logic                       w_do_merge;
    logic                       w_push;
    logic                       w_drop;
    logic [DCCM_DATA_WIDTH-1:0] w_head_data;
    logic                       w_unused_addr_lsb;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_DEPTH_CNT);
    assign w_pop    = ~w_empty & bus.wr_gnt;
    assign w_accept = bus.corr_valid & ~bus.ecc_disable;

    // Byte offset within the word never takes part in matching or storage.
    assign w_unused_addr_lsb = ^bus.corr_addr[1:0];

    // An entry is live when its distance from the head is below the count.
    // The head entry being written this cycle is excluded from merging: its
    // data is already on the write port, so a new entry must be made.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        logic [c_PTR_W-1:0] w_off;
        logic               w_live;
        assign w_off    = c_PTR_W'(gi) - r_head;
        assign w_live   = ({1'b0, w_off} < r_count);
        assign w_hit[gi] = w_live
                         & ~(w_pop & (r_head == c_PTR_W'(gi)))
                         & (r_addr[gi] == bus.corr_addr[DCCM_BITS-1:2]);
    end

    always_comb begin
        w_merge_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_merge_idx = c_PTR_W'(i);
            end
        end
    end

    assign w_merge    = |w_hit;
    assign w_do_merge = w_accept & w_merge;
    assign w_push     = w_accept & ~w_merge & (~w_full | w_pop);
    assign w_drop     = w_accept & ~w_merge & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= bus.corr_addr[DCCM_BITS-1:2];
                r_data[r_tail] <= bus.corr_data;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_do_merge) begin
                r_data[w_merge_idx] <= bus.corr_data;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Clear has priority over a same-cycle increment.
            if (bus.cnt_clr) begin
                r_cnt <= '0;
            end else if ((w_push | w_do_merge) && (r_cnt != {CNT_WIDTH{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_drop <= w_drop;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Write port is quiet (all zero) whenever the queue is empty.
    assign w_head_data = w_empty ? '0 : r_data[r_head];
    assign bus.wr_req  = ~w_empty;
    assign bus.wr_addr = w_empty ? '0 : {r_addr[r_head], 2'b00};
    assign bus.wr_data = {f_ecc(w_head_data), w_head_data};

    assign bus.corr_cnt   = r_cnt;
    assign bus.full       = w_full;
    assign bus.drop_pulse = r_drop;
    assign bus.overflow   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_eh2_lsu_ecc_corr_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_eh2_lsu_ecc_corr_wb
// Purpose  : Self-checking bench for eh2_lsu_ecc_corr_wb. A vector table
//            drives the main sequence; expected writes live in a scoreboard
//            queue and are compared when a granted write occurs. Hand-written
//            sequences cover counter saturation and reset flush.
// Revision : 1.0  initial release
// ============================================================================
module tb_eh2_lsu_ecc_corr_wb;
    localparam int BITS  = 16;
    localparam int DW    = 32;
    localparam int EW    = 7;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;   // narrow counter so saturation is reached quickly

    localparam int K_NONE  = 0;
    localparam int K_PUSH  = 1;
    localparam int K_MERGE = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eh2_lsu_ecc_corr_wb_if #(.DCCM_BITS(BITS), .DCCM_DATA_WIDTH(DW),
                             .DCCM_ECC_WIDTH(EW), .CNT_WIDTH(CNT_W)) bus ();

    eh2_lsu_ecc_corr_wb #(.DCCM_BITS(BITS), .DCCM_DATA_WIDTH(DW), .DCCM_ECC_WIDTH(EW),
                          .DEPTH(DEPTH), .CNT_WIDTH(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic [15:0] addr;
        logic [31:0] data;
        logic        dis;
        logic        gnt;
        logic        clr;
        int          kind;
        logic        e_req;
        logic        e_full;
        logic [7:0]  e_cnt;
        logic        e_drop;
        logic        e_ovf;
    } vec_t;

    typedef struct {
        logic [13:0] wa;
        logic [31:0] d;
    } ent_t;

    ent_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Golden SEC-DED: place data bits at non-power-of-two Hamming positions,
    // check bit k covers positions with bit k set, bit 6 is overall parity.
    function automatic logic [6:0] gold_ecc(input logic [31:0] d);
        logic [38:0] cw;
        logic [6:0]  e;
        int          j;
        cw = '0;
        e  = '0;
        j  = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            for (int p = 1; p <= 38; p++) begin
                if (((p >> k) & 1) != 0) e[k] = e[k] ^ cw[p];
            end
        end
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    function automatic vec_t mk(logic v, logic [15:0] a, logic [31:0] d, logic dis,
                                logic gnt, logic clr, int kind, logic req, logic fl,
                                logic [7:0] cnt, logic drp, logic ovf);
        vec_t r;
        r.v = v; r.addr = a; r.data = d; r.dis = dis; r.gnt = gnt; r.clr = clr;
        r.kind = kind; r.e_req = req; r.e_full = fl; r.e_cnt = cnt;
        r.e_drop = drp; r.e_ovf = ovf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [31:0] d,
                         input logic dis, input logic gnt, input logic clr, input int kind);
        bus.corr_valid  = v;
        bus.corr_addr   = a;
        bus.corr_data   = d;
        bus.ecc_disable = dis;
        bus.wr_gnt      = gnt;
        bus.cnt_clr     = clr;
        if (kind == K_PUSH) begin
            sb.push_back('{wa: a[15:2], d: d});
        end else if (kind == K_MERGE) begin
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].wa == a[15:2]) begin
                    sb[i].d = d;
                    break;
                end
            end
        end
    endtask

    // One clock: at the negedge, a granted write is checked against the
    // scoreboard head; returns #1 after the following posedge.
    task automatic tick();
        @(negedge clk);
        if (bus.wr_req === 1'b1 && bus.wr_gnt === 1'b1) begin
            chk("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                chk("wr_addr", 64'(bus.wr_addr), 64'({sb[0].wa, 2'b00}));
                chk("wr_data", 64'(bus.wr_data), 64'({gold_ecc(sb[0].d), sb[0].d}));
                void'(sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag);
        if (sb.size() != 0) begin
            chk({tag, "_addr"}, 64'(bus.wr_addr), 64'({sb[0].wa, 2'b00}));
            chk({tag, "_data"}, 64'(bus.wr_data), 64'({gold_ecc(sb[0].d), sb[0].d}));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"},  64'(bus.wr_req),     64'd0);
        chk({tag, "_addr"}, 64'(bus.wr_addr),    64'd0);
        chk({tag, "_data"}, 64'(bus.wr_data),    64'd0);
        chk({tag, "_cnt"},  64'(bus.corr_cnt),   64'd0);
        chk({tag, "_full"}, 64'(bus.full),       64'd0);
        chk({tag, "_drop"}, 64'(bus.drop_pulse), 64'd0);
        chk({tag, "_ovf"},  64'(bus.overflow),   64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[21];

        vecs[0]  = mk(1, 16'h0104, 32'h0000_0000, 0, 0, 0, K_PUSH,  1, 0, 8'd1, 0, 0);
        vecs[1]  = mk(0, 16'h0000, 32'h0,         0, 0, 0, K_NONE,  1, 0, 8'd1, 0, 0);
        vecs[2]  = mk(0, 16'h0000, 32'h0,         0, 0, 0, K_NONE,  1, 0, 8'd1, 0, 0);
        vecs[3]  = mk(0, 16'h0000, 32'h0,         0, 1, 0, K_NONE,  0, 0, 8'd1, 0, 0);
        vecs[4]  = mk(1, 16'h0010, 32'hFFFF_FFFF, 0, 1, 0, K_PUSH,  1, 0, 8'd2, 0, 0);
        vecs[5]  = mk(1, 16'h0014, 32'h1234_5678, 0, 1, 0, K_PUSH,  1, 0, 8'd3, 0, 0);
        vecs[6]  = mk(0, 16'h0000, 32'h0,         0, 1, 0, K_NONE,  0, 0, 8'd3, 0, 0);
        vecs[7]  = mk(1, 16'h0020, 32'hDEAD_BEEF, 0, 0, 0, K_PUSH,  1, 0, 8'd4, 0, 0);
        vecs[8]  = mk(1, 16'h0024, 32'h0F0F_0F0F, 0, 0, 0, K_PUSH,  1, 1, 8'd5, 0, 0);
        vecs[9]  = mk(1, 16'h0028, 32'h1357_9BDF, 0, 0, 0, K_NONE,  1, 1, 8'd5, 1, 1);
        vecs[10] = mk(0, 16'h0000, 32'h0,         0, 0, 0, K_NONE,  1, 1, 8'd5, 0, 1);
        vecs[11] = mk(1, 16'h0024, 32'hA5A5_A5A5, 0, 0, 0, K_MERGE, 1, 1, 8'd6, 0, 1);
        vecs[12] = mk(1, 16'h0020, 32'h8000_0001, 0, 1, 0, K_PUSH,  1, 1, 8'd7, 0, 1);
        vecs[13] = mk(1, 16'h0024, 32'h0000_0001, 0, 0, 0, K_MERGE, 1, 1, 8'd8, 0, 1);
        vecs[14] = mk(0, 16'h0000, 32'h0,         0, 1, 0, K_NONE,  1, 0, 8'd8, 0, 1);
        vecs[15] = mk(0, 16'h0000, 32'h0,         0, 1, 0, K_NONE,  0, 0, 8'd8, 0, 1);
        vecs[16] = mk(1, 16'h0040, 32'hCAFE_F00D, 0, 0, 0, K_PUSH,  1, 0, 8'd9, 0, 1);
        vecs[17] = mk(1, 16'h0030, 32'h1111_2222, 1, 0, 0, K_NONE,  1, 0, 8'd9, 0, 1);
        vecs[18] = mk(1, 16'h0034, 32'h3333_4444, 1, 1, 0, K_NONE,  0, 0, 8'd9, 0, 1);
        vecs[19] = mk(1, 16'h0053, 32'h5A5A_0000, 0, 0, 1, K_PUSH,  1, 0, 8'd0, 0, 1);
        vecs[20] = mk(0, 16'h0000, 32'h0,         0, 1, 0, K_NONE,  0, 0, 8'd0, 0, 1);

        // Reset
        rst = 1'b1;
        drive(0, 16'h0, 32'h0, 0, 0, 0, K_NONE);
        tick();
        tick();
        chk_reset_state("reset");
        rst = 1'b0;

        // Table-driven main sequence
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].v, vecs[i].addr, vecs[i].data, vecs[i].dis,
                  vecs[i].gnt, vecs[i].clr, vecs[i].kind);
            tick();
            chk($sformatf("v%0d_req", i),  64'(bus.wr_req),     64'(vecs[i].e_req));
            chk($sformatf("v%0d_full", i), 64'(bus.full),       64'(vecs[i].e_full));
            chk($sformatf("v%0d_cnt", i),  64'(bus.corr_cnt),   64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_drop", i), 64'(bus.drop_pulse), 64'(vecs[i].e_drop));
            chk($sformatf("v%0d_ovf", i),  64'(bus.overflow),   64'(vecs[i].e_ovf));
            if (vecs[i].e_req) chk_head($sformatf("v%0d_head", i));
        end
        chk("table_sb_drained", 64'(sb.size()), 64'd0);

        // Counter saturation via repeated merges into one entry
        rst = 1'b1;
        drive(0, 16'h0, 32'h0, 0, 0, 0, K_NONE);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(1, 16'h0060, 32'(i), 0, 0, 0, (i == 0) ? K_PUSH : K_MERGE);
            tick();
            if (i == 254) chk("sat_reach", 64'(bus.corr_cnt), 64'hFF);
        end
        chk("sat_hold", 64'(bus.corr_cnt), 64'hFF);
        chk("sat_no_drop", 64'(bus.overflow), 64'd0);
        chk_head("sat_head");
        drive(1, 16'h0060, 32'h7777_8888, 0, 0, 1, K_MERGE);
        tick();
        chk("clr_wins", 64'(bus.corr_cnt), 64'd0);
        drive(0, 16'h0, 32'h0, 0, 1, 0, K_NONE);
        tick();
        chk("sat_drained", 64'(bus.wr_req), 64'd0);

        // Reset flushes a full queue and the sticky overflow
        drive(1, 16'h0070, 32'h0BAD_CAFE, 0, 0, 0, K_PUSH);
        tick();
        drive(1, 16'h0074, 32'hFEED_FACE, 0, 0, 0, K_PUSH);
        tick();
        drive(1, 16'h0078, 32'h0000_FFFF, 0, 0, 0, K_NONE);
        tick();
        chk("flush_full", 64'(bus.full), 64'd1);
        chk("flush_ovf", 64'(bus.overflow), 64'd1);
        rst = 1'b1;
        drive(0, 16'h0, 32'h0, 0, 0, 0, K_NONE);
        tick();
        rst = 1'b0;
        sb.delete();
        chk_reset_state("flush");
        drive(0, 16'h0, 32'h0, 0, 1, 0, K_NONE);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("flush_idle%0d", i), 64'(bus.wr_req), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
